// File: rtl/servo_pkg.sv
// Shared types, default timing constants and pulse-width helpers for servo channels.
// Kept channel-agnostic so a second (pan) servo can reuse clamp/slew unchanged.
package servo_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StHigh,
        StLow
    } servo_state_e;

    localparam int unsigned TICK_DIV_DEF  = 100;
    localparam int unsigned FRAME_US_DEF  = 20000;
    localparam int unsigned PULSE_MIN_DEF = 1000;
    localparam int unsigned PULSE_MAX_DEF = 2000;
    localparam int unsigned PULSE_CTR_DEF = 1500;
    localparam int unsigned SLEW_STEP_DEF = 20;

    localparam int unsigned US_W  = 11;
    localparam int unsigned CNT_W = 15;

    function automatic logic [US_W-1:0] clamp_us(
        input logic [US_W-1:0] val,
        input logic [US_W-1:0] lo,
        input logic [US_W-1:0] hi
    );
        if (val < lo) begin
            return lo;
        end
        if (val > hi) begin
            return hi;
        end
        return val;
    endfunction

    // One extra bit of headroom so cur+step never wraps; result re-clamped to the window.
    function automatic logic [US_W-1:0] slew_us(
        input logic [US_W-1:0] cur,
        input logic [US_W-1:0] tgt,
        input logic [US_W-1:0] step,
        input logic [US_W-1:0] lo,
        input logic [US_W-1:0] hi
    );
        logic [US_W:0] c;
        logic [US_W:0] t;
        logic [US_W:0] s;
        logic [US_W:0] r;
        c = {1'b0, cur};
        t = {1'b0, tgt};
        s = {1'b0, step};
        if (t > c + s) begin
            r = c + s;
        end else if (t + s < c) begin
            r = c - s;
        end else begin
            r = t;
        end
        if (r < {1'b0, lo}) begin
            r = {1'b0, lo};
        end else if (r > {1'b0, hi}) begin
            r = {1'b0, hi};
        end
        return r[US_W-1:0];
    endfunction

endpackage

// File: rtl/us_tick_gen.sv
// Microsecond prescaler: emits a 1-clk tick every TICK_DIV clocks, restarted by clr.
module us_tick_gen #(
    parameter int unsigned TICK_DIV = 100
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int unsigned W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (clr || (cnt_q == LAST)) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + W'(1);
        end
    end

    assign tick = !clr && (cnt_q == LAST);

endmodule

// File: rtl/servo_pulse_sequencer.sv
// Servo frame scheduler: clamps incoming samples, slew-limits once per frame in LOAD,
// then drives one PWM pulse of pulse_cur microseconds per FRAME_US frame.
module servo_pulse_sequencer
    import servo_pkg::*;
#(
    parameter int unsigned TICK_DIV  = TICK_DIV_DEF,
    parameter int unsigned FRAME_US  = FRAME_US_DEF,
    parameter int unsigned PULSE_MIN = PULSE_MIN_DEF,
    parameter int unsigned PULSE_MAX = PULSE_MAX_DEF,
    parameter int unsigned PULSE_CTR = PULSE_CTR_DEF,
    parameter int unsigned SLEW_STEP = SLEW_STEP_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [US_W-1:0]  y_val_lim,
    input  logic             val_valid,
    output logic             servo_pwm,
    output logic             frame_start,
    output logic             sample_ack,
    output logic [US_W-1:0]  pulse_cur
);

    localparam logic [US_W-1:0]  P_MIN   = US_W'(PULSE_MIN);
    localparam logic [US_W-1:0]  P_MAX   = US_W'(PULSE_MAX);
    localparam logic [US_W-1:0]  P_CTR   = US_W'(PULSE_CTR);
    localparam logic [US_W-1:0]  P_STEP  = US_W'(SLEW_STEP);
    localparam logic [CNT_W-1:0] LAST_US = CNT_W'(FRAME_US - 1);

    servo_state_e     state_q;
    logic [CNT_W-1:0] us_q;
    logic [US_W-1:0]  target_q;
    logic [US_W-1:0]  pulse_q;
    logic             pwm_q;
    logic             fs_q;
    logic             ack_q;

    logic             tick;
    logic             tick_clr;
    logic [CNT_W-1:0] pulse_last;

    assign tick_clr   = (state_q == StIdle) || (state_q == StLoad);
    assign pulse_last = {{(CNT_W - US_W){1'b0}}, pulse_q} - CNT_W'(1);

    us_tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick (
        .clk (clk),
        .rst (rst),
        .clr (tick_clr),
        .tick(tick)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= StIdle;
            us_q     <= '0;
            target_q <= P_CTR;
            pulse_q  <= P_CTR;
            pwm_q    <= 1'b0;
            fs_q     <= 1'b0;
            ack_q    <= 1'b0;
        end else begin
            ack_q <= val_valid;
            fs_q  <= 1'b0;
            // Capture in every state; in LOAD the slew below still sees the old target.
            if (val_valid) begin
                target_q <= clamp_us(y_val_lim, P_MIN, P_MAX);
            end

            unique case (state_q)
                StIdle: begin
                    us_q  <= '0;
                    pwm_q <= 1'b0;
                    if (enable) begin
                        state_q <= StLoad;
                        fs_q    <= 1'b1;
                    end
                end
                StLoad: begin
                    pulse_q <= slew_us(pulse_q, target_q, P_STEP, P_MIN, P_MAX);
                    us_q    <= '0;
                    pwm_q   <= 1'b1;
                    state_q <= StHigh;
                end
                StHigh: begin
                    if (tick) begin
                        us_q <= us_q + CNT_W'(1);
                        if (us_q == pulse_last) begin
                            pwm_q   <= 1'b0;
                            state_q <= StLow;
                        end
                    end
                end
                StLow: begin
                    if (tick) begin
                        if (us_q == LAST_US) begin
                            // enable only matters at frame end, never truncating a frame.
                            us_q <= '0;
                            if (enable) begin
                                state_q <= StLoad;
                                fs_q    <= 1'b1;
                            end else begin
                                state_q <= StIdle;
                            end
                        end else begin
                            us_q <= us_q + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                    pwm_q   <= 1'b0;
                end
            endcase
        end
    end

    assign servo_pwm   = pwm_q;
    assign frame_start = fs_q;
    assign sample_ack  = ack_q;
    assign pulse_cur   = pulse_q;

endmodule

// File: tb/tb_servo_pulse_sequencer.sv
// Bench for servo_pulse_sequencer: a fast instance (TICK_DIV=1) and a prescaled,
// wide-slew instance (TICK_DIV=2) with a shortened frame to keep runtime small.
module tb_servo_pulse_sequencer;

    localparam int FRAME = 2050;
    localparam int TD2   = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        en1;
    logic        en2;
    logic        vv;
    logic [10:0] y;

    logic        pwm1, fs1, ack1;
    logic [10:0] pc1;
    logic        pwm2, fs2, ack2;
    logic [10:0] pc2;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit sel     = 1'b0;

    logic        mon_pwm;
    logic        mon_fs;
    logic [10:0] mon_pc;

    logic [10:0] exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        mon_pwm = sel ? pwm2 : pwm1;
        mon_fs  = sel ? fs2 : fs1;
        mon_pc  = sel ? pc2 : pc1;
    end

    servo_pulse_sequencer #(
        .TICK_DIV(1),
        .FRAME_US(FRAME)
    ) dut1 (
        .clk        (clk),
        .rst        (rst),
        .enable     (en1),
        .y_val_lim  (y),
        .val_valid  (vv),
        .servo_pwm  (pwm1),
        .frame_start(fs1),
        .sample_ack (ack1),
        .pulse_cur  (pc1)
    );

    servo_pulse_sequencer #(
        .TICK_DIV (TD2),
        .FRAME_US (FRAME),
        .SLEW_STEP(1000)
    ) dut2 (
        .clk        (clk),
        .rst        (rst),
        .enable     (en2),
        .y_val_lim  (y),
        .val_valid  (vv),
        .servo_pwm  (pwm2),
        .frame_start(fs2),
        .sample_ack (ack2),
        .pulse_cur  (pc2)
    );

    task automatic wait_fs(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            @(negedge clk);
            if (mon_fs) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Called on the frame_start sample; returns HIGH length in clocks and pulse_cur.
    task automatic measure_pulse(output int width, output logic [10:0] pc);
        width = 0;
        @(negedge clk);
        vv = 1'b0;
        pc = mon_pc;
        while (mon_pwm && width < 20000) begin
            width++;
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        en1 = 1'b0;
        en2 = 1'b0;
        vv  = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        bit ok;
        int act;
        rst = 1'b0; en1 = 1'b0; en2 = 1'b0; vv = 1'b0; y = '0;
        repeat (3) @(negedge clk);
        n_tests++; if (pwm1 !== 1'b0) begin n_fail++; $display("FAIL rst_pwm: got %b want 0", pwm1); end
        n_tests++; if (pc1 !== 11'd1500) begin n_fail++; $display("FAIL rst_pc: got %0d want 1500", pc1); end
        n_tests++; if (fs1 !== 1'b0 || ack1 !== 1'b0) begin n_fail++; $display("FAIL rst_strobes: got fs=%b ack=%b want 0", fs1, ack1); end
        n_tests++; if (pc2 !== 11'd1500 || pwm2 !== 1'b0) begin n_fail++; $display("FAIL rst_dut2: got pc=%0d pwm=%b want 1500/0", pc2, pwm2); end
        rst = 1'b1;
        en1 = 1'b1;
        sel = 1'b0;
        wait_fs(ok);
        repeat (100) @(negedge clk);
        n_tests++; if (pwm1 !== 1'b1) begin n_fail++; $display("FAIL rst_prehigh: got %b want 1", pwm1); end
        rst = 1'b0;
        en1 = 1'b0;
        @(negedge clk);
        n_tests++; if (pwm1 !== 1'b0) begin n_fail++; $display("FAIL rst_midhigh_pwm: got %b want 0", pwm1); end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        act = 0;
        repeat (50) begin
            @(negedge clk);
            if (pwm1 || fs1) act++;
        end
        n_tests++; if (act !== 0) begin n_fail++; $display("FAIL rst_idle: got %0d active cycles want 0", act); end
    endtask

    task automatic test_basic();
        bit ok;
        int t, t_prev, w;
        logic [10:0] pc, e;
        sel = 1'b0;
        t_prev = 0;
        repeat (3) exp_q.push_back(11'd1500);
        en1 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_fs(ok);
            n_tests++; if (!ok) begin n_fail++; $display("FAIL basic_fs: got timeout want frame_start"); end
            t = cyc;
            if (k > 0) begin
                n_tests++;
                if (t - t_prev !== FRAME + 1) begin
                    n_fail++; $display("FAIL basic_period: got %0d want %0d", t - t_prev, FRAME + 1);
                end
            end
            t_prev = t;
            measure_pulse(w, pc);
            e = exp_q.pop_front();
            n_tests++; if (w !== int'(e)) begin n_fail++; $display("FAIL basic_width: got %0d want %0d", w, e); end
            n_tests++; if (pc !== e) begin n_fail++; $display("FAIL basic_pc: got %0d want %0d", pc, e); end
        end
    endtask

    task automatic test_slew();
        bit ok;
        int w;
        logic [10:0] pc, e;
        y  = 11'd1200;
        vv = 1'b1;
        @(negedge clk);
        vv = 1'b0;
        n_tests++; if (ack1 !== 1'b1) begin n_fail++; $display("FAIL slew_ack: got %b want 1", ack1); end
        @(negedge clk);
        n_tests++; if (ack1 !== 1'b0) begin n_fail++; $display("FAIL slew_ack_len: got %b want 0", ack1); end
        for (int i = 0; i < 15; i++) exp_q.push_back(11'(1480 - 20 * i));
        repeat (2) exp_q.push_back(11'd1200);
        for (int k = 0; k < 17; k++) begin
            wait_fs(ok);
            n_tests++; if (!ok) begin n_fail++; $display("FAIL slew_fs: got timeout want frame_start"); end
            measure_pulse(w, pc);
            e = exp_q.pop_front();
            n_tests++; if (pc !== e) begin n_fail++; $display("FAIL slew_pc: got %0d want %0d", pc, e); end
            n_tests++; if (w !== int'(e)) begin n_fail++; $display("FAIL slew_width: got %0d want %0d", w, e); end
        end
    endtask

    task automatic test_enable_drop();
        bit ok;
        int t0, w, act;
        logic [10:0] pc;
        // Drop enable mid-pulse but raise it again in LOW: frame must run to full length.
        wait_fs(ok);
        t0 = cyc;
        w = 0;
        @(negedge clk);
        while (pwm1 && w < 20000) begin
            w++;
            if (w == 10) en1 = 1'b0;
            @(negedge clk);
        end
        n_tests++; if (w !== 1200) begin n_fail++; $display("FAIL drop_width_a: got %0d want 1200", w); end
        repeat (5) @(negedge clk);
        en1 = 1'b1;
        wait_fs(ok);
        n_tests++; if (!ok || cyc - t0 !== FRAME + 1) begin n_fail++; $display("FAIL drop_period: got %0d want %0d", cyc - t0, FRAME + 1); end
        w = 0;
        @(negedge clk);
        while (pwm1 && w < 20000) begin
            w++;
            if (w == 10) en1 = 1'b0;
            @(negedge clk);
        end
        n_tests++; if (w !== 1200) begin n_fail++; $display("FAIL drop_width_b: got %0d want 1200", w); end
        act = 0;
        repeat (FRAME + 100) begin
            @(negedge clk);
            if (pwm1 || fs1) act++;
        end
        n_tests++; if (act !== 0) begin n_fail++; $display("FAIL drop_idle: got %0d active cycles want 0", act); end
        en1 = 1'b1;
        @(negedge clk);
        n_tests++; if (fs1 !== 1'b1) begin n_fail++; $display("FAIL reenable_fs: got %b want 1", fs1); end
        measure_pulse(w, pc);
        n_tests++; if (w !== 1200 || pc !== 11'd1200) begin n_fail++; $display("FAIL reenable_pulse: got %0d/%0d want 1200", w, pc); end
    endtask

    task automatic test_load_sample();
        bit ok;
        int w;
        logic [10:0] pc, e;
        do_reset();
        sel = 1'b0;
        exp_q.push_back(11'd1500);
        exp_q.push_back(11'd1520);
        en1 = 1'b1;
        wait_fs(ok);
        // Sample lands on the LOAD cycle itself.
        y  = 11'd1600;
        vv = 1'b1;
        for (int k = 0; k < 2; k++) begin
            if (k > 0) wait_fs(ok);
            n_tests++; if (!ok) begin n_fail++; $display("FAIL load_fs: got timeout want frame_start"); end
            measure_pulse(w, pc);
            e = exp_q.pop_front();
            n_tests++; if (pc !== e || w !== int'(e)) begin n_fail++; $display("FAIL load_pulse: got %0d/%0d want %0d", pc, w, e); end
        end
    endtask

    task automatic test_small_step();
        bit ok;
        int w;
        logic [10:0] pc, e;
        do_reset();
        sel = 1'b0;
        y  = 11'd1510;
        vv = 1'b1;
        @(negedge clk);
        vv  = 1'b0;
        en1 = 1'b1;
        repeat (2) exp_q.push_back(11'd1510);
        for (int k = 0; k < 2; k++) begin
            wait_fs(ok);
            n_tests++; if (!ok) begin n_fail++; $display("FAIL step_fs: got timeout want frame_start"); end
            measure_pulse(w, pc);
            e = exp_q.pop_front();
            n_tests++; if (pc !== e || w !== int'(e)) begin n_fail++; $display("FAIL step_pulse: got %0d/%0d want %0d", pc, w, e); end
        end
        en1 = 1'b0;
    endtask

    task automatic test_clamp();
        bit ok;
        int t0, w;
        logic [10:0] pc, e;
        logic [10:0] vals[7];
        vals = '{11'd0, 11'd999, 11'd1000, 11'd1234, 11'd2000, 11'd2001, 11'd2047};
        do_reset();
        sel = 1'b1;
        for (int i = 0; i < 7; i++) begin
            y  = vals[i];
            vv = 1'b1;
            @(negedge clk);
            vv = 1'b0;
            e = (vals[i] < 11'd1000) ? 11'd1000 : (vals[i] > 11'd2000) ? 11'd2000 : vals[i];
            n_tests++; if (dut2.target_q !== e) begin n_fail++; $display("FAIL clamp_target: got %0d want %0d", dut2.target_q, e); end
        end
        y  = 11'd400;
        vv = 1'b1;
        @(negedge clk);
        vv = 1'b0;
        exp_q.push_back(11'd1000);
        exp_q.push_back(11'd2000);
        en2 = 1'b1;
        wait_fs(ok);
        t0 = cyc;
        measure_pulse(w, pc);
        e = exp_q.pop_front();
        n_tests++; if (pc !== e || w !== int'(e) * TD2) begin n_fail++; $display("FAIL clamp_low: got %0d/%0d want %0d/%0d", pc, w, e, int'(e) * TD2); end
        y  = 11'd2047;
        vv = 1'b1;
        @(negedge clk);
        vv = 1'b0;
        wait_fs(ok);
        n_tests++; if (!ok || cyc - t0 !== FRAME * TD2 + 1) begin n_fail++; $display("FAIL clamp_period: got %0d want %0d", cyc - t0, FRAME * TD2 + 1); end
        measure_pulse(w, pc);
        e = exp_q.pop_front();
        n_tests++; if (pc !== e || w !== int'(e) * TD2) begin n_fail++; $display("FAIL clamp_high: got %0d/%0d want %0d/%0d", pc, w, e, int'(e) * TD2); end
        en2 = 1'b0;
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_slew();
        test_enable_drop();
        test_load_sample();
        test_small_step();
        test_clamp();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
